// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: command opcodes and sequencer FSM states.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } opcode_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_RESP  = 2'b10
   } seq_state_e;

   localparam int OPCODE_W = 2;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue stage; DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo #(
   parameter int W     = 18,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_q;

   // Storage carries no reset: entries are only read once the count says they were written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the combinational ALU: buffers commands, issues one at a time, returns registered results.
// Optional macro ALU_OVERFLOW_FLAG_EN adds the signed-overflow flag output out_overflow.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [1:0]                    in_opcode,
   input  logic [WIDTH-1:0]              in_a,
   input  logic [WIDTH-1:0]              in_b,
   output logic [1:0]                    alu_opcode,
   output logic [WIDTH-1:0]              alu_a,
   output logic [WIDTH-1:0]              alu_b,
   input  logic [WIDTH-1:0]              alu_result,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_result,
   output logic [1:0]                    out_opcode,
`ifdef ALU_OVERFLOW_FLAG_EN
   output logic                          out_overflow,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy,
   output seq_state_e                    dbg_state
);

   localparam int CW = OPCODE_W + 2*WIDTH;

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high; a
   // source holds valid and its payload stable until that edge, ready may toggle freely.

   seq_state_e       state_q, state_d;
   logic             push, pop, capture, clear_valid;
   logic             fifo_full, fifo_empty;
   logic [CW-1:0]    cmd_head;
   logic [1:0]       alu_op_q, out_op_q;
   logic [WIDTH-1:0] alu_a_q, alu_b_q, out_res_q;
   logic             out_valid_q;

   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready;

   alu_cmd_fifo #(.W(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     ({in_opcode, in_a, in_b}),
      .dout    (cmd_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      capture     = 1'b0;
      clear_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            capture = 1'b1;
            state_d = S_RESP;
         end
         S_RESP: begin
            // out_valid drops for the ISSUE cycle so a result is never offered twice.
            if (out_ready) begin
               clear_valid = 1'b1;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = S_ISSUE;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef ALU_OVERFLOW_FLAG_EN
   logic ovf_d, out_ovf_q;

   always_comb begin
      ovf_d = 1'b0;
      case (opcode_e'(alu_op_q))
         OP_ADD:  ovf_d = (alu_a_q[WIDTH-1] == alu_b_q[WIDTH-1]) && (alu_result[WIDTH-1] != alu_a_q[WIDTH-1]);
         OP_SUB:  ovf_d = (alu_a_q[WIDTH-1] != alu_b_q[WIDTH-1]) && (alu_result[WIDTH-1] != alu_a_q[WIDTH-1]);
         default: ovf_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     out_ovf_q <= 1'b0;
      else if (capture) out_ovf_q <= ovf_d;
   end

   assign out_overflow = out_ovf_q;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         alu_op_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         out_op_q    <= '0;
         out_res_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (pop) begin
            alu_op_q <= cmd_head[CW-1 -: OPCODE_W];
            alu_a_q  <= cmd_head[2*WIDTH-1 -: WIDTH];
            alu_b_q  <= cmd_head[WIDTH-1:0];
         end
         if (capture) begin
            out_res_q   <= alu_result;
            out_op_q    <= alu_op_q;
            out_valid_q <= 1'b1;
         end else if (clear_valid) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign alu_opcode = alu_op_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_res_q;
   assign out_opcode = out_op_q;
   assign busy       = (state_q != S_IDLE) || (fifo_count != '0);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed + randomized bench for alu_op_sequencer with a queue-based reference model and ALU stubs.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int W2 = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset_n;
   logic             in_valid, in_ready, out_valid, out_ready, busy;
   logic [1:0]       in_opcode, alu_opcode, out_opcode;
   logic [W-1:0]     in_a, in_b, alu_a, alu_b, alu_result, out_result;
   logic [$clog2(D):0] fifo_count;
   seq_state_e       dbg_state;
   logic             out_overflow;

   logic              in16_valid, in16_ready, out16_valid, out16_ready, busy16;
   logic [1:0]        in16_opcode, alu16_opcode, out16_opcode;
   logic [W2-1:0]     in16_a, in16_b, alu16_a, alu16_b, alu16_result, out16_result;
   logic [$clog2(D):0] fifo16_count;
   seq_state_e        dbg16_state;
   logic              out16_overflow;

   alu_op_sequencer #(.WIDTH(W), .FIFO_DEPTH(D)) u_dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_opcode(out_opcode),
`ifdef ALU_OVERFLOW_FLAG_EN
      .out_overflow(out_overflow),
`endif
      .fifo_count(fifo_count), .busy(busy), .dbg_state(dbg_state)
   );

   alu_op_sequencer #(.WIDTH(W2), .FIFO_DEPTH(D)) u_dut16 (
      .clk(clk), .reset_n(reset_n), .in_valid(in16_valid), .in_ready(in16_ready),
      .in_opcode(in16_opcode), .in_a(in16_a), .in_b(in16_b),
      .alu_opcode(alu16_opcode), .alu_a(alu16_a), .alu_b(alu16_b), .alu_result(alu16_result),
      .out_valid(out16_valid), .out_ready(out16_ready), .out_result(out16_result), .out_opcode(out16_opcode),
`ifdef ALU_OVERFLOW_FLAG_EN
      .out_overflow(out16_overflow),
`endif
      .fifo_count(fifo16_count), .busy(busy16), .dbg_state(dbg16_state)
   );

`ifndef ALU_OVERFLOW_FLAG_EN
   assign out_overflow   = 1'b0;
   assign out16_overflow = 1'b0;
`endif

   // Combinational ALU stubs standing in for the real ALU.
   always_comb begin
      alu_result = '0;
      case (alu_opcode)
         2'b00: alu_result = alu_a + alu_b;
         2'b01: alu_result = alu_a - alu_b;
         2'b10: alu_result = alu_a & alu_b;
         2'b11: alu_result = alu_a | alu_b;
         default: alu_result = '0;
      endcase
   end

   always_comb begin
      alu16_result = '0;
      case (alu16_opcode)
         2'b00: alu16_result = alu16_a + alu16_b;
         2'b01: alu16_result = alu16_a - alu16_b;
         2'b10: alu16_result = alu16_a & alu16_b;
         2'b11: alu16_result = alu16_a | alu16_b;
         default: alu16_result = '0;
      endcase
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [W-1:0] exp_q[$];
   logic [1:0]   exp_op_q[$];
   logic         exp_ovf_q[$];
   int           dlv_cyc_q[$];
   bit           last_acc, last_dlv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: signed integer arithmetic, result wrapped to W bits, overflow = out of signed range.
   task automatic model_accept(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int sa, sb, r;
      bit ovf;
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      r   = 0;
      ovf = 1'b0;
      case (op)
         2'b00: r = sa + sb;
         2'b01: r = sa - sb;
         2'b10: r = sa & sb;
         default: r = sa | sb;
      endcase
      if (op < 2'b10) ovf = (r > 127) || (r < -128);
      exp_q.push_back(r[W-1:0]);
      exp_op_q.push_back(op);
      exp_ovf_q.push_back(ovf);
   endtask

   // One clock: sample handshakes before the edge, update the model, return at the next negedge.
   task automatic cycle();
      bit hold;
      logic [W-1:0] held_res;
      last_acc = in_valid && in_ready;
      last_dlv = out_valid && out_ready;
      hold     = out_valid && !out_ready;
      held_res = out_result;
      if (last_dlv) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(out_result), 32'hFFFF_FFFF);
         end else begin
            check("result", 32'(out_result), 32'(exp_q[0]));
            check("opcode", 32'(out_opcode), 32'(exp_op_q[0]));
`ifdef ALU_OVERFLOW_FLAG_EN
            check("overflow", 32'(out_overflow), 32'(exp_ovf_q[0]));
`endif
            void'(exp_q.pop_front());
            void'(exp_op_q.pop_front());
            void'(exp_ovf_q.pop_front());
            dlv_cyc_q.push_back(cyc);
         end
      end
      if (last_acc) model_accept(in_opcode, in_a, in_b);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (hold) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_result", 32'(out_result), 32'(held_res));
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      in_valid  = 1'b1;
      in_opcode = op;
      in_a      = a;
      in_b      = b;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!last_acc && n < 50);
      check("send_accepted", 32'(last_acc), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 100) begin
         cycle();
         n++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("drain_idle", 32'(busy), 32'd0);
   endtask

   task automatic run16(input logic [1:0] op, input logic [W2-1:0] a, input logic [W2-1:0] b,
                        input logic [W2-1:0] exp, input string tag);
      int n;
      in16_valid = 1'b1; in16_opcode = op; in16_a = a; in16_b = b;
      out16_ready = 1'b1;
      check({tag, "_in_ready"}, 32'(in16_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      in16_valid = 1'b0;
      n = 0;
      while (!out16_valid && n < 20) begin
         @(posedge clk); @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, 32'(out16_valid), 32'd1);
      check(tag, 32'(out16_result), 32'(exp));
      @(posedge clk); @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0;
      in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
      in16_valid = 1'b0; in16_opcode = '0; in16_a = '0; in16_b = '0; out16_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Reset state
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_out_result", 32'(out_result), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(S_IDLE));

      // Latency of a single ADD 10,20
      out_ready = 1'b1;
      send(2'b00, 8'd10, 8'd20);
      check("lat_n_valid", 32'(out_valid), 32'd0);
      check("lat_n_count", 32'(fifo_count), 32'd1);
      cycle();
      check("lat_n1_alu_a", 32'(alu_a), 32'd10);
      check("lat_n1_alu_b", 32'(alu_b), 32'd20);
      check("lat_n1_alu_op", 32'(alu_opcode), 32'd0);
      check("lat_n1_valid", 32'(out_valid), 32'd0);
      cycle();
      check("lat_n2_valid", 32'(out_valid), 32'd1);
      check("lat_n2_result", 32'(out_result), 32'd30);
      drain();

      // SUB / AND / OR of 10,20
      send(2'b01, 8'd10, 8'd20); drain();
      send(2'b10, 8'd10, 8'd20); drain();
      send(2'b11, 8'd10, 8'd20); drain();

      // Back-pressure with five queued commands
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_opcode = 2'(i); in_a = 8'(3 * i + 1); in_b = 8'(i + 2);
         cycle();
         check("bp_accept", 32'(last_acc), 32'd1);
      end
      in_valid = 1'b0;
      check("bp_count_full", 32'(fifo_count), 32'd4);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_first_result", 32'(out_result), 32'(exp_q[0]));
      repeat (3) cycle();
      dlv_cyc_q.delete();
      out_ready = 1'b1;
      cycle();
      check("bp_in_ready_back", 32'(in_ready), 32'd1);
      check("bp_count_after_pop", 32'(fifo_count), 32'd3);
      drain();
      check("bp_deliveries", 32'(dlv_cyc_q.size()), 32'd5);
      for (int i = 1; i < dlv_cyc_q.size(); i++)
         check("bp_spacing", 32'(dlv_cyc_q[i] - dlv_cyc_q[i-1]), 32'd2);

      // Push and pop in the same cycle at count 2
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_opcode = 2'b00; in_a = 8'(40 + i); in_b = 8'(i);
         cycle();
      end
      check("pp_count_before", 32'(fifo_count), 32'd2);
      check("pp_state", 32'(dbg_state), 32'(S_RESP));
      in_opcode = 2'b11; in_a = 8'h0F; in_b = 8'hF0;
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      check("pp_push_pop", 32'(last_acc && last_dlv), 32'd1);
      check("pp_count_after", 32'(fifo_count), 32'd2);
      drain();

      // Signed overflow corners
      send(2'b00, 8'd127, 8'd1);  drain();
      send(2'b01, 8'h80, 8'd1);   drain();
      send(2'b00, 8'd5, 8'd3);    drain();

      // Randomized traffic with random back-pressure
      for (int i = 0; i < 400; i++) begin
         if (!in_valid || last_acc) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_opcode = 2'($urandom_range(0, 3));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
         end
         out_ready = ($urandom_range(0, 99) < 55);
         cycle();
      end
      in_valid = 1'b0;
      drain();

      // Reset while a result is pending and three commands are queued
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_opcode = 2'b01; in_a = 8'(i); in_b = 8'd1;
         cycle();
      end
      in_valid = 1'b0;
      check("mid_count", 32'(fifo_count), 32'd3);
      check("mid_state", 32'(dbg_state), 32'(S_RESP));
      reset_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_count", 32'(fifo_count), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      exp_q.delete(); exp_op_q.delete(); exp_ovf_q.delete();
      @(posedge clk); @(negedge clk);
      reset_n = 1'b1;
      check("rel_in_ready", 32'(in_ready), 32'd1);
      check("rel_alu_a", 32'(alu_a), 32'd0);
      check("rel_state", 32'(dbg_state), 32'(S_IDLE));
      repeat (3) cycle();
      check("rel_quiet", 32'(out_valid), 32'd0);

      // Wider instance
      run16(2'b00, 16'd230, 16'd300, 16'd530, "w16_add");
`ifdef ALU_OVERFLOW_FLAG_EN
      check("w16_add_ovf", 32'(out16_overflow), 32'd0);
`endif
      run16(2'b01, 16'd230, 16'd300, 16'hFFBA, "w16_sub");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
